// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and
// helper functions used by both the receive and (future) transmit sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  localparam int unsigned OVERSAMPLE = 16;

  localparam logic [3:0] SC_SAMPLE_A = 4'd7;
  localparam logic [3:0] SC_SAMPLE_B = 4'd8;
  localparam logic [3:0] SC_DECIDE   = 4'd9;
  localparam logic [3:0] SC_LAST     = 4'd15;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned tick_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
  endfunction

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_8e1_if.sv
// Receive status bundle: byte, completion strobe, error flags and busy.
interface uart_rx_8e1_if;
  logic [7:0] read_value;
  logic       read_complete;
  logic       read_error;
  logic       parity_error;
  logic       frame_error;
  logic       busy;

  modport master (
    output read_value, read_complete, read_error, parity_error, frame_error, busy
  );

  modport slave (
    input read_value, read_complete, read_error, parity_error, frame_error, busy
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks;
// a synchronous clear restarts the phase.
module uart_baud_tick #(
  parameter int unsigned DIV = 326
) (
  input  logic clk_50M,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || cnt == W'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == W'(DIV - 1)) && !clr;
endmodule

// File: rtl/uart_rx_8e1.sv
// 8E1 UART receiver: 2-FF synchroniser, 16x oversampling with 3-sample
// majority vote, registered byte/parity/frame status.
module uart_rx_8e1
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic            clk_50M,
  input  logic            reset,
  input  logic            uart_rxd,
  uart_rx_8e1_if.master   rx
);
  localparam int unsigned TICK_DIV = tick_div(CLK_FREQ, BAUD);

  uart_state_t state;
  logic        rxd_meta, rxd_s;
  logic [3:0]  sc;
  logic [2:0]  idx;
  logic        smp_a, smp_b;
  logic [7:0]  shreg;
  logic        pbit;
  logic        brk_high;
  logic        tick, tick_clr;
  logic        vote, par_bad;

  logic [7:0]  rd_value;
  logic        rd_complete, rd_error, par_err, frm_err, busy_r;

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
    end
  end

  assign tick_clr = (state == IDLE) && !rxd_s;

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk_50M (clk_50M),
    .reset   (reset),
    .clr     (tick_clr),
    .tick    (tick)
  );

  // Third sample is the live synchronised line at sc = 9.
  assign vote    = majority3(smp_a, smp_b, rxd_s);
  assign par_bad = even_parity(shreg) ^ pbit;

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sc          <= '0;
      idx         <= '0;
      smp_a       <= 1'b1;
      smp_b       <= 1'b1;
      shreg       <= '0;
      pbit        <= 1'b0;
      brk_high    <= 1'b0;
      rd_value    <= '0;
      rd_complete <= 1'b0;
      rd_error    <= 1'b0;
      par_err     <= 1'b0;
      frm_err     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rd_complete <= 1'b0;
      case (state)
        IDLE: begin
          busy_r <= 1'b0;
          if (!rxd_s) begin
            sc     <= '0;
            state  <= START;
            busy_r <= 1'b1;
          end
        end

        // Leave only after the line has been high for a whole tick period.
        BREAK: begin
          if (!rxd_s) brk_high <= 1'b0;
          if (tick) begin
            if (brk_high && rxd_s) begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end else begin
              brk_high <= rxd_s;
            end
          end
        end

        default: begin
          if (tick) begin
            sc <= sc + 4'd1;
            if (sc == SC_SAMPLE_A) smp_a <= rxd_s;
            if (sc == SC_SAMPLE_B) smp_b <= rxd_s;
            case (state)
              START: begin
                if (sc == SC_DECIDE && vote) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
                end else if (sc == SC_LAST) begin
                  state <= DATA;
                  idx   <= '0;
                end
              end
              DATA: begin
                if (sc == SC_DECIDE) shreg[idx] <= vote;
                if (sc == SC_LAST) begin
                  if (idx == 3'd7) state <= PARITY;
                  else             idx   <= idx + 3'd1;
                end
              end
              PARITY: begin
                if (sc == SC_DECIDE) pbit  <= vote;
                if (sc == SC_LAST)   state <= STOP;
              end
              // Decide at the stop midpoint so an early next start bit is caught.
              STOP: begin
                if (sc == SC_DECIDE) begin
                  rd_value    <= shreg;
                  par_err     <= par_bad;
                  frm_err     <= ~vote;
                  rd_error    <= par_bad | ~vote;
                  rd_complete <= 1'b1;
                  if (vote) begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                  end else begin
                    state    <= BREAK;
                    brk_high <= 1'b0;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign rx.read_value    = rd_value;
  assign rx.read_complete = rd_complete;
  assign rx.read_error    = rd_error;
  assign rx.parity_error  = par_err;
  assign rx.frame_error   = frm_err;
  assign rx.busy          = busy_r;
endmodule

// File: tb/tb_uart_rx_8e1.sv
// Directed bench for uart_rx_8e1; baud is raised to 312500 (TICK_DIV = 10,
// 160 clocks per bit, 3200 time units per bit) to keep frames short.
module tb_uart_rx_8e1;
  localparam int BIT_T = 3200;

  logic clk_50M = 1'b0;
  logic reset   = 1'b1;
  logic uart_rxd = 1'b1;

  uart_rx_8e1_if rx ();

  uart_rx_8e1 #(.CLK_FREQ(50_000_000), .BAUD(312_500)) dut (
    .clk_50M  (clk_50M),
    .reset    (reset),
    .uart_rxd (uart_rxd),
    .rx       (rx)
  );

  always #10 clk_50M = ~clk_50M;

  int n_pass  = 0;
  int n_total = 0;

  int         pulse_cnt = 0;
  logic [7:0] val_log[$];
  logic       err_log[$];
  time        t_log[$];

  always @(negedge clk_50M) begin
    if (rx.read_complete) begin
      pulse_cnt++;
      val_log.push_back(rx.read_value);
      err_log.push_back(rx.read_error);
      t_log.push_back($time);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         bit_t;
    logic [7:0] exp_val;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_re;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic [7:0] d, input logic p, input logic s,
                              input int bt, input logic [7:0] ev,
                              input logic pe, input logic fe, input logic re);
    vec_t v;
    v.data = d; v.par = p; v.stop = s; v.bit_t = bt;
    v.exp_val = ev; v.exp_pe = pe; v.exp_fe = fe; v.exp_re = re;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int bt);
    uart_rxd = 1'b0;
    #bt;
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      #bt;
    end
    uart_rxd = p;
    #bt;
    uart_rxd = s;
    #bt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
    $fatal(1);
  end

  initial begin
    int base;
    logic [7:0] d12;

    vecs[0] = mk(8'h78, 1'b0, 1'b1, BIT_T,       8'h78, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk(8'hDE, 1'b1, 1'b1, BIT_T,       8'hDE, 1'b1, 1'b0, 1'b1);
    vecs[2] = mk(8'h00, 1'b0, 1'b1, BIT_T + 64,  8'h00, 1'b0, 1'b0, 1'b0);
    vecs[3] = mk(8'hFF, 1'b0, 1'b1, BIT_T - 64,  8'hFF, 1'b0, 1'b0, 1'b0);
    vecs[4] = mk(8'h01, 1'b1, 1'b1, BIT_T + 64,  8'h01, 1'b0, 1'b0, 1'b0);
    vecs[5] = mk(8'h80, 1'b0, 1'b1, BIT_T - 64,  8'h80, 1'b1, 1'b0, 1'b1);
    vecs[6] = mk(8'h3C, 1'b0, 1'b0, BIT_T,       8'h3C, 1'b0, 1'b1, 1'b1);

    // Reset state
    repeat (3) @(negedge clk_50M);
    check("reset read_value",    32'(rx.read_value),    32'h00);
    check("reset read_complete", 32'(rx.read_complete), 32'h0);
    check("reset read_error",    32'(rx.read_error),    32'h0);
    check("reset busy",          32'(rx.busy),          32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk_50M);

    for (int i = 0; i < 7; i++) begin
      base = pulse_cnt;
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].bit_t);
      uart_rxd = 1'b1;
      #(2 * BIT_T);
      check($sformatf("vec%0d pulses", i),       32'(pulse_cnt - base),     32'd1);
      check($sformatf("vec%0d read_value", i),   32'(rx.read_value),        32'(vecs[i].exp_val));
      check($sformatf("vec%0d parity_error", i), 32'(rx.parity_error),      32'(vecs[i].exp_pe));
      check($sformatf("vec%0d frame_error", i),  32'(rx.frame_error),       32'(vecs[i].exp_fe));
      check($sformatf("vec%0d read_error", i),   32'(rx.read_error),        32'(vecs[i].exp_re));
      check($sformatf("vec%0d busy idle", i),    32'(rx.busy),              32'h0);
    end

    // Back-to-back frames with no idle bits
    base = pulse_cnt;
    send_frame(8'h9A, 1'b0, 1'b1, BIT_T);
    send_frame(8'hBC, 1'b1, 1'b1, BIT_T);
    uart_rxd = 1'b1;
    #(2 * BIT_T);
    check("b2b pulses", 32'(pulse_cnt - base), 32'd2);
    if (val_log.size() >= base + 2) begin
      check("b2b first value",  32'(val_log[base]),     32'h9A);
      check("b2b second value", 32'(val_log[base + 1]), 32'hBC);
      check("b2b first error",  32'(err_log[base]),     32'h0);
      check("b2b second error", 32'(err_log[base + 1]), 32'h0);
      check("b2b spacing in 35200+-100",
            32'((t_log[base + 1] - t_log[base] >= 35100) &&
                (t_log[base + 1] - t_log[base] <= 35300)), 32'h1);
    end

    // Short low glitch, plus start-edge to busy latency
    base = pulse_cnt;
    @(posedge clk_50M);
    #1 uart_rxd = 1'b0;
    @(posedge clk_50M);
    @(posedge clk_50M);
    #1 check("busy latency 2 clk", 32'(rx.busy), 32'h0);
    @(posedge clk_50M);
    #1 check("busy latency 3 clk", 32'(rx.busy), 32'h1);
    repeat (47) @(posedge clk_50M);
    #1 uart_rxd = 1'b1;
    repeat (160) @(posedge clk_50M);
    #1;
    check("glitch busy cleared", 32'(rx.busy),           32'h0);
    check("glitch no pulse",     32'(pulse_cnt - base),  32'd0);
    check("glitch value held",   32'(rx.read_value),     32'hBC);

    // Low stop bit followed by a held-low line
    base = pulse_cnt;
    send_frame(8'h55, 1'b0, 1'b0, BIT_T);
    #(3 * BIT_T);
    check("break pulses",       32'(pulse_cnt - base), 32'd1);
    check("break read_value",   32'(rx.read_value),    32'h55);
    check("break frame_error",  32'(rx.frame_error),   32'h1);
    check("break parity_error", 32'(rx.parity_error),  32'h0);
    check("break read_error",   32'(rx.read_error),    32'h1);
    check("break busy held",    32'(rx.busy),          32'h1);
    uart_rxd = 1'b1;
    #(2 * BIT_T);
    check("break no retrigger", 32'(pulse_cnt - base), 32'd1);
    check("break busy cleared", 32'(rx.busy),          32'h0);

    // Reset during data bit 4 of 0x12
    base = pulse_cnt;
    d12 = 8'h12;
    uart_rxd = 1'b0;
    #BIT_T;
    for (int i = 0; i < 4; i++) begin
      uart_rxd = d12[i];
      #BIT_T;
    end
    uart_rxd = d12[4];
    #(BIT_T / 2);
    reset = 1'b1;
    @(negedge clk_50M);
    check("midreset read_value",  32'(rx.read_value),  32'h00);
    check("midreset frame_error", 32'(rx.frame_error), 32'h0);
    check("midreset read_error",  32'(rx.read_error),  32'h0);
    check("midreset busy",        32'(rx.busy),        32'h0);
    repeat (5) @(negedge clk_50M);
    uart_rxd = 1'b1;
    reset = 1'b0;
    #(2 * BIT_T);
    check("midreset no pulse", 32'(pulse_cnt - base), 32'd0);
    send_frame(8'h34, 1'b1, 1'b1, BIT_T);
    uart_rxd = 1'b1;
    #(2 * BIT_T);
    check("post-reset pulses",     32'(pulse_cnt - base), 32'd1);
    check("post-reset read_value", 32'(rx.read_value),    32'h34);
    check("post-reset read_error", 32'(rx.read_error),    32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
